// File: rtl/proj1_pkg.sv
// Shared proj1 constants and the store-trace entry record.
package proj1_pkg;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEQ_W  = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } trace_entry_t;
endpackage

// File: rtl/store_trace_mem.sv
// Store-trace entry array: one synchronous write port, one asynchronous read port.
module store_trace_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/store_trace_fifo.sv
// Taps the CPU write port and queues each store edge as {addr, data, seq}.
// Optional address window filter: define STORE_TRACE_FILTER_EN.
module store_trace_fifo #(
    parameter int unsigned       DEPTH   = 8,
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DATA_W  = 16,
    parameter logic [ADDR_W-1:0] FILT_LO = '0,
    parameter logic [ADDR_W-1:0] FILT_HI = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MemRW_IO,
    input  logic [ADDR_W-1:0]          MemAddr_IO,
    input  logic [DATA_W-1:0]          MemD_IO,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic [proj1_pkg::SEQ_W-1:0] out_seq,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [7:0]                 drop_cnt
);
    import proj1_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W + SEQ_W;

    logic             rw_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [7:0]       drop_q, drop_d;
    logic             accept, push, pop, wr_en;
    logic [ENT_W-1:0] rd_entry;

`ifdef STORE_TRACE_FILTER_EN
    assign accept = (MemAddr_IO >= FILT_LO) && (MemAddr_IO <= FILT_HI);
`else
    logic unused_filt;
    assign unused_filt = ^{FILT_LO, FILT_HI};
    assign accept = 1'b1;
`endif

    assign full  = count_q == CNT_W'(DEPTH);
    assign empty = count_q == '0;

    always_comb begin
        push     = MemRW_IO & ~rw_q & accept;
        pop      = ~empty & out_ready;
        // A full FIFO still takes the store when the head leaves this cycle
        wr_en    = push & (~full | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push) seq_d = seq_q + 8'd1;
        if (push && !wr_en && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            rw_q     <= MemRW_IO;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    store_trace_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({MemAddr_IO, MemD_IO, seq_q}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Gate fields so they read 0 rather than stale or unwritten storage
    assign out_valid = ~empty;
    assign out_addr  = out_valid ? rd_entry[ENT_W-1 -: ADDR_W] : '0;
    assign out_data  = out_valid ? rd_entry[SEQ_W +: DATA_W] : '0;
    assign out_seq   = out_valid ? rd_entry[SEQ_W-1:0] : '0;
    assign count     = count_q;
    assign drop_cnt  = drop_q;
endmodule
